// File: rtl/remap_accel_addr_gen.sv
// rtl/remap_accel_addr_gen.sv - pipelined y*cols+x address generator with frame FSM
// One coordinate per handshake in, one flat address (with out-of-range flag) out.
module remap_accel_addr_gen #(
  parameter int W       = 11,
  parameter int AW      = 22,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  cfg_cols,
  input  logic [W-1:0]  cfg_rows,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_x,
  input  logic [W-1:0]  s_y,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic          m_oob,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   oob_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t state, state_nxt;

  logic [W-1:0]       cols_q, rows_q;
  logic [W-1:0]       col_cnt, row_cnt;
  logic               adv, accept, oob_in, last_acc, drain_ok;
  logic [MUL_LAT-1:0] vld;
  logic [MUL_LAT-1:0] oob_d;
  logic [AW-1:0]      prod [MUL_LAT];
  logic [W-1:0]       x_d  [MUL_LAT];

  // adv is the single global stall for every pipeline register
  assign adv      = ~m_valid | m_ready;
  assign accept   = s_valid & s_ready;
  assign oob_in   = (s_x >= cols_q) | (s_y >= rows_q);
  assign last_acc = (col_cnt == cols_q - ONE) && (row_cnt == rows_q - ONE);
  assign drain_ok = ~(|vld) & adv;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_cols == '0 || cfg_rows == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        s_ready = adv;
        if (accept && last_acc) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cols_q     <= '0;
      rows_q     <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
      oob_count  <= '0;
    end else begin
      frame_done <= (state == DRAIN) && drain_ok;
      if (state == IDLE && start) begin
        cols_q    <= cfg_cols;
        rows_q    <= cfg_rows;
        col_cnt   <= '0;
        row_cnt   <= '0;
        oob_count <= '0;
      end else begin
        if (m_valid && m_ready && m_oob && oob_count != 16'hFFFF) begin
          oob_count <= oob_count + 16'd1;
        end
        if (accept) begin
          if (col_cnt == cols_q - ONE) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ONE;
          end else begin
            col_cnt <= col_cnt + ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld     <= '0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_oob   <= 1'b0;
    end else if (adv) begin
      vld     <= {vld[MUL_LAT-2:0], accept};
      m_valid <= vld[MUL_LAT-1];
      if (vld[MUL_LAT-1]) begin
        m_addr <= oob_d[MUL_LAT-1] ? '0 : prod[MUL_LAT-1] + AW'(x_d[MUL_LAT-1]);
        m_oob  <= oob_d[MUL_LAT-1];
      end
    end
  end

  // Multiplier stages and the x/oob delay lines share the same enable
  always_ff @(posedge clk) begin
    if (adv) begin
      prod[0] <= AW'(s_y) * AW'(cols_q);
      x_d[0]  <= s_x;
      oob_d   <= {oob_d[MUL_LAT-2:0], oob_in};
      for (int i = 1; i < MUL_LAT; i++) begin
        prod[i] <= prod[i-1];
        x_d[i]  <= x_d[i-1];
      end
    end
  end

endmodule

// File: tb/tb_remap_accel_addr_gen.sv
// tb/tb_remap_accel_addr_gen.sv - scoreboard bench for remap_accel_addr_gen
module tb_remap_accel_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n, start, s_valid, s_ready, m_valid, m_ready, m_oob, busy, frame_done;
  logic [10:0] cfg_cols, cfg_rows, s_x, s_y;
  logic [21:0] m_addr;
  logic [15:0] oob_count;

  remap_accel_addr_gen #(.W(11), .AW(22), .MUL_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_oob(m_oob),
    .busy(busy), .frame_done(frame_done), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] addr;
    logic        oob;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, fd_count = 0, out_count = 0;
  int          lat_acc_cyc = 0, lat_meas = -1;
  bit          lat_first = 0, lat_arm = 0, bp_mode = 0;
  int          bp_idx = 0;
  logic [4:0]  bp_pat = 5'b01001;
  bit          stalled_prev = 0;
  logic [21:0] held_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // m_ready driver: constant 1 or the repeating 1,0,0,1,0 pattern
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      m_ready = bp_mode ? bp_pat[bp_idx % 5] : 1'b1;
      if (bp_mode) bp_idx++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done) fd_count++;
  end

  // Monitor: pops the scoreboard on each output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (stalled_prev) begin
          check("stall_hold_valid", m_valid, 1);
          check("stall_hold_addr", m_addr, held_addr);
        end
        if (m_valid && !m_ready) begin
          check("s_ready_low_in_stall", s_ready, 0);
          stalled_prev = 1;
          held_addr    = m_addr;
        end else begin
          stalled_prev = 0;
        end
        if (lat_arm && m_valid) begin
          lat_meas = cyc - lat_acc_cyc;
          lat_arm  = 0;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got addr %0d expected no output", m_addr);
          end else begin
            e = exp_q.pop_front();
            check("m_addr", m_addr, e.addr);
            check("m_oob", m_oob, e.oob);
            out_count++;
          end
        end
      end else begin
        stalled_prev = 0;
      end
    end
  end

  task automatic send(input int x, input int y, input int ea, input logic eo);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_x     = 11'(x);
    s_y     = 11'(y);
    #1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (s_ready) begin
      exp_q.push_back({22'(ea), eo});
      if (lat_first) begin
        lat_acc_cyc = cyc;
        lat_arm     = 1;
        lat_first   = 0;
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_start(input int c, input int r);
    @(negedge clk);
    cfg_cols = 11'(c);
    cfg_rows = 11'(r);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string name);
    int n = 0;
    while (fd_count < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, fd_count, target);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_oob", m_oob, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_oob_count", oob_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_x      = '0;
    s_y      = '0;
    cfg_cols = '0;
    cfg_rows = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;

    // Basic 4x3 raster frame: addresses 0..11
    lat_first = 1;
    do_start(4, 3);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 12; i++) send(i % 4, i / 4, i, 1'b0);
    idle_in();
    wait_fd(1, "basic_frame_done");
    wait_empty();
    check("basic_latency", lat_meas, 5);
    check("basic_out_count", out_count, 12);
    check("basic_oob_count", oob_count, 0);
    check("basic_busy_idle", busy, 0);

    // Largest dimensions and coordinate
    do_start(2047, 2047);
    send(2046, 2046, 4190208, 1'b0);
    idle_in();
    wait_empty();
    check("max_busy", busy, 1);
    do_reset();

    // Out-of-range coordinates
    do_start(10, 5);
    send(10, 0, 0, 1'b1);
    send(3, 5, 0, 1'b1);
    send(9, 4, 49, 1'b0);
    idle_in();
    wait_empty();
    @(negedge clk);
    check("oob_count_2", oob_count, 2);
    do_reset();

    // Backpressure on a 4x4 frame, with an ignored start mid-run
    bp_mode = 1;
    do_start(4, 4);
    for (int i = 0; i < 16; i++) begin
      send(i % 4, i / 4, i, 1'b0);
      if (i == 5) begin
        idle_in();
        do_start(7, 7);
      end
    end
    idle_in();
    wait_fd(2, "bp_frame_done");
    wait_empty();
    bp_mode = 0;
    check("bp_out_count", out_count, 12 + 1 + 3 + 16);

    // Reset in the middle of a frame
    do_start(8, 8);
    for (int i = 0; i < 6; i++) send(i, 0, i, 1'b0);
    do_reset();
    repeat (10) @(negedge clk);
    check("midreset_no_done", fd_count, 2);
    check("midreset_m_valid", m_valid, 0);

    // Zero-dimension frame completes without accepting anything
    @(negedge clk);
    cfg_cols = 11'd0;
    cfg_rows = 11'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("zero_fd_early", frame_done, 0);
    check("zero_busy", busy, 1);
    check("zero_s_ready_1", s_ready, 0);
    @(negedge clk);
    check("zero_fd_pulse", frame_done, 1);
    check("zero_s_ready_2", s_ready, 0);
    @(negedge clk);
    check("zero_fd_single", frame_done, 0);
    check("zero_busy_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
